// File: rtl/expr_pipe_eval_pkg.sv
// Shared types for the lane-parallel expression pipeline.
// Holds the operation encoding and the result-width helper.
package expr_pipe_eval_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_XNOR  = 3'd2,
        OP_EQ    = 3'd3,
        OP_LE    = 3'd4,
        OP_SHR   = 3'd5,
        OP_MUL   = 3'd6,
        OP_RXNOR = 3'd7
    } op_e;

    localparam int OP_W = 3;

    function automatic int res_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/expr_pipe_eval_if.sv
// Valid/ready bundle between the pipeline and its producer/consumer.
// master drives operands and out_ready; slave is the pipeline view.
interface expr_pipe_eval_if #(
    parameter int LANES = 6,
    parameter int W     = 6
);
    import expr_pipe_eval_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [OP_W-1:0]            op;
    logic [LANES*W-1:0]         a;
    logic [LANES*W-1:0]         b;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*res_w(W)-1:0]  y;
    logic [15:0]                txn_count;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, txn_count
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, txn_count
    );

endinterface

// File: rtl/expr_pipe_eval_lane.sv
// One combinational operand lane: extends A/B to 2*W and applies op.
// Signedness is fixed per instance.
module expr_lane
    import expr_pipe_eval_pkg::*;
#(
    parameter int W      = 6,
    parameter bit SIGNED = 1'b0
) (
    input  op_e              op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   y
);

    localparam int RW = 2 * W;
    localparam int SW = $clog2(RW);

    logic [RW-1:0] ax;
    logic [RW-1:0] bx;
    logic [SW-1:0] shamt;
    logic          le;

    assign ax    = SIGNED ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    assign bx    = SIGNED ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    assign shamt = bx[SW-1:0];
    assign le    = SIGNED ? ($signed(ax) <= $signed(bx)) : (ax <= bx);

    always_comb begin
        y = '0;
        unique case (op)
            OP_ADD:   y = ax + bx;
            OP_SUB:   y = ax - bx;
            OP_XNOR:  y = ~(ax ^ bx);
            OP_EQ:    y = {{(RW-1){1'b0}}, ax == bx};
            OP_LE:    y = {{(RW-1){1'b0}}, le};
            OP_SHR:   y = SIGNED ? RW'($signed(ax) >>> shamt) : (ax >> shamt);
            OP_MUL:   y = ax * bx;
            OP_RXNOR: y = {{(RW-1){1'b0}}, ~^{a, b}};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/expr_pipe_eval.sv
// Lane-parallel expression evaluator with a stall-all valid/ready pipe.
// Results form in stage 1 and shift through STAGES-1 delay registers.
module expr_pipe_eval
    import expr_pipe_eval_pkg::*;
#(
    parameter int               LANES       = 6,
    parameter int               W           = 6,
    parameter logic [LANES-1:0] SIGNED_MASK = 6'b111000,
    parameter int               STAGES      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                op,
    input  logic [LANES*W-1:0]        a,
    input  logic [LANES*W-1:0]        b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*2*W-1:0]      y,
    output logic [15:0]               txn_count
);

    localparam int RW = res_w(W);
    localparam int YW = LANES * RW;

    logic [YW-1:0]                 res;
    logic [STAGES-1:0]             valid_q;
    logic [STAGES-1:0][YW-1:0]     data_q;
    logic [15:0]                   txn_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        expr_lane #(
            .W      (W),
            .SIGNED (SIGNED_MASK[i])
        ) u_lane (
            .op (op_e'(op)),
            .a  (a[(LANES-1-i)*W +: W]),
            .b  (b[(LANES-1-i)*W +: W]),
            .y  (res[(LANES-1-i)*RW +: RW])
        );
    end

    assign out_valid = valid_q[STAGES-1];
    assign y         = data_q[STAGES-1];
    assign in_ready  = out_ready || !out_valid;
    assign txn_count = txn_q;

    // One global enable: a stalled output freezes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            txn_q   <= '0;
        end else begin
            if (in_ready) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= res;
                end
                for (int s = 1; s < STAGES; s++) begin
                    valid_q[s] <= valid_q[s-1];
                    data_q[s]  <= data_q[s-1];
                end
            end
            if (out_valid && out_ready) begin
                txn_q <= txn_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_expr_pipe_eval.sv
// Directed bench for expr_pipe_eval: vector table streamed back-to-back
// plus hand sequences for latency, stall, reset and counter wrap.
module tb_expr_pipe_eval;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    expr_pipe_eval_if #(.LANES(6), .W(6)) bus ();

    expr_pipe_eval dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .op        (bus.op),
        .a         (bus.a),
        .b         (bus.b),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .y         (bus.y),
        .txn_count (bus.txn_count)
    );

    typedef struct {
        logic [2:0]  op;
        int          lane;
        logic [5:0]  a;
        logic [5:0]  b;
        logic [11:0] exp;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] lane_of(input logic [71:0] yv,
                                            input int l);
        return 12'(yv >> ((5 - l) * 12));
    endfunction

    task automatic drive(input logic [2:0] o, input int l,
                         input logic [5:0] av, input logic [5:0] bv);
        logic [35:0] ta;
        logic [35:0] tb;
        ta = '0;
        tb = '0;
        ta[(5-l)*6 +: 6] = av;
        tb[(5-l)*6 +: 6] = bv;
        bus.op = o;
        bus.a = ta;
        bus.b = tb;
        bus.in_valid = 1'b1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 80'(bus.out_valid), 80'd0);
        chk("rst_y", 80'(bus.y), 80'd0);
        chk("rst_txn", 80'(bus.txn_count), 80'd0);
        chk("rst_in_ready", 80'(bus.in_ready), 80'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;

        vt[0]  = '{3'd0, 5, 6'b111101, 6'd5,      12'h002};
        vt[1]  = '{3'd0, 0, 6'd63,     6'd63,     12'd126};
        vt[2]  = '{3'd6, 0, 6'd63,     6'd63,     12'd3969};
        vt[3]  = '{3'd5, 3, 6'b111000, 6'd2,      12'hFFE};
        vt[4]  = '{3'd5, 2, 6'b111000, 6'd2,      12'd14};
        vt[5]  = '{3'd1, 4, 6'd2,      6'd5,      12'hFFD};
        vt[6]  = '{3'd1, 1, 6'd0,      6'd1,      12'hFFF};
        vt[7]  = '{3'd4, 3, 6'd63,     6'd1,      12'h001};
        vt[8]  = '{3'd4, 1, 6'd63,     6'd1,      12'h000};
        vt[9]  = '{3'd3, 2, 6'd17,     6'd17,     12'h001};
        vt[10] = '{3'd6, 5, 6'b100000, 6'b100000, 12'h400};
        vt[11] = '{3'd6, 4, 6'b111101, 6'd7,      12'hFEB};
        vt[12] = '{3'd2, 0, 6'b101010, 6'b110011, 12'hFE6};
        vt[13] = '{3'd2, 5, 6'b101010, 6'b000101, 12'h010};
        vt[14] = '{3'd7, 0, 6'd1,      6'd0,      12'h000};
        vt[15] = '{3'd7, 3, 6'd3,      6'd0,      12'h001};
        vt[16] = '{3'd5, 4, 6'b100000, 6'd15,     12'hFFF};
        vt[17] = '{3'd5, 1, 6'd63,     6'd3,      12'h007};

        do_reset();

        // Latency: result appears exactly two cycles after acceptance.
        drive(vt[0].op, vt[0].lane, vt[0].a, vt[0].b);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("lat_cycle1_valid", 80'(bus.out_valid), 80'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 80'(bus.out_valid), 80'd1);
        chk("lat_lane5_add", 80'(lane_of(bus.y, 5)), 80'h002);
        @(negedge clk);
        chk("lat_drain_valid", 80'(bus.out_valid), 80'd0);
        chk("lat_txn", 80'(bus.txn_count), 80'd1);

        // Table streamed at one bundle per cycle.
        do_reset();
        for (int i = 0; i < NV + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk($sformatf("vec%0d_valid", i - 2),
                    80'(bus.out_valid), 80'd1);
                chk($sformatf("vec%0d_op%0d_lane%0d", i - 2, vt[i-2].op,
                              vt[i-2].lane),
                    80'(lane_of(bus.y, vt[i-2].lane)), 80'(vt[i-2].exp));
            end
            if (i < NV) drive(vt[i].op, vt[i].lane, vt[i].a, vt[i].b);
            else bus.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("stream_txn", 80'(bus.txn_count), 80'(NV));
        chk("stream_drain", 80'(bus.out_valid), 80'd0);

        // Backpressure: three bundles against a stalled consumer.
        do_reset();
        bus.out_ready = 1'b0;
        drive(3'd0, 0, 6'd1, 6'd1);
        chk("bp_rdy_a", 80'(bus.in_ready), 80'd1);
        @(negedge clk);
        drive(3'd0, 0, 6'd2, 6'd2);
        chk("bp_rdy_b", 80'(bus.in_ready), 80'd1);
        @(negedge clk);
        drive(3'd0, 0, 6'd3, 6'd3);
        chk("bp_full_valid", 80'(bus.out_valid), 80'd1);
        chk("bp_full_rdy", 80'(bus.in_ready), 80'd0);
        chk("bp_head_a", 80'(lane_of(bus.y, 0)), 80'd2);
        @(negedge clk);
        chk("bp_hold_rdy", 80'(bus.in_ready), 80'd0);
        chk("bp_hold_y", 80'(lane_of(bus.y, 0)), 80'd2);
        chk("bp_hold_txn", 80'(bus.txn_count), 80'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_out_b_valid", 80'(bus.out_valid), 80'd1);
        chk("bp_out_b", 80'(lane_of(bus.y, 0)), 80'd4);
        @(negedge clk);
        chk("bp_out_c_valid", 80'(bus.out_valid), 80'd1);
        chk("bp_out_c", 80'(lane_of(bus.y, 0)), 80'd6);
        @(negedge clk);
        chk("bp_drain", 80'(bus.out_valid), 80'd0);
        chk("bp_txn", 80'(bus.txn_count), 80'd3);

        // Reset while a result is held and txn_count is 5.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(3'd0, 1, 6'(i), 6'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst5_txn", 80'(bus.txn_count), 80'd5);
        bus.out_ready = 1'b0;
        drive(3'd6, 0, 6'd7, 6'd7);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst5_held_valid", 80'(bus.out_valid), 80'd1);
        chk("rst5_held_y", 80'(lane_of(bus.y, 0)), 80'd49);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 80'(bus.out_valid), 80'd0);
        chk("arst_y", 80'(bus.y), 80'd0);
        chk("arst_txn", 80'(bus.txn_count), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("arst_no_stale%0d", i), 80'(bus.out_valid), 80'd0);
        end
        chk("arst_txn_after", 80'(bus.txn_count), 80'd0);

        // Counter wrap after 65535 + 1 transfers.
        do_reset();
        drive(3'd0, 0, 6'd1, 6'd2);
        repeat (65535) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrap_ffff", 80'(bus.txn_count), 80'hFFFF);
        chk("wrap_drained", 80'(bus.out_valid), 80'd0);
        drive(3'd0, 0, 6'd1, 6'd2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_last_y", 80'(lane_of(bus.y, 0)), 80'd3);
        @(negedge clk);
        chk("wrap_zero", 80'(bus.txn_count), 80'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_pipe_eval.md
EXPR_PIPE_EVAL -- requirements
Module: expr_pipe_eval

Interface
REQ-001 SHALL have parameter LANES, default 6, number of independent operand lanes.
REQ-002 SHALL have parameter W, default 6, operand width per lane; result width per lane is 2*W.
REQ-003 SHALL have parameter SIGNED_MASK, default 6'b111000, LANES bits; bit i = 1 marks lane i signed.
REQ-004 SHALL have parameter STAGES, default 2, pipeline depth (>= 1).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  operand bundle valid.
REQ-008 SHALL have port in_ready  output  1  block accepts bundle this cycle.
REQ-009 SHALL have port op  input  3  operation code, shared by all lanes.
REQ-010 SHALL have port a  input  LANES*W  lane operands A, lane 0 in MSBs.
REQ-011 SHALL have port b  input  LANES*W  lane operands B, lane 0 in MSBs.
REQ-012 SHALL have port out_valid  output  1  result bundle valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port y  output  LANES*2*W  lane results concatenated, lane 0 in MSBs.
REQ-015 SHALL have port txn_count  output  16  completed output transactions.

Function
REQ-016 Each lane SHALL extend A and B to 2*W bits: sign-extend if signed lane, zero-extend otherwise, before any operation.
REQ-017 op encoding SHALL be: 0 add, 1 sub (A-B), 2 bitwise xnor, 3 equality, 4 A<=B, 5 A shifted right by B[log2(2W)-1:0] (arithmetic if signed lane, logical otherwise), 6 multiply, 7 reduction-xnor of {A,B} at original width.
REQ-018 Ops 3, 4 and 7 SHALL produce a 1-bit result zero-extended to 2*W; comparison uses lane signedness.
REQ-019 Add, sub and multiply SHALL be truncated to 2*W bits, no saturation, no overflow flag.
REQ-020 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-021 in_ready SHALL equal out_ready || !out_valid (combinational, global stall).
REQ-022 Lane results SHALL be computed in stage 1 and delayed through STAGES-1 further registers; latency from input transfer to out_valid = STAGES cycles with no stall.
REQ-023 When in_ready is 0 all stage registers and stage valid bits SHALL hold.
REQ-024 When in_ready is 1 each stage valid SHALL load the preceding stage valid (stage 1 loads in_valid); bubbles propagate.
REQ-025 y SHALL be stable while out_valid && !out_ready.
REQ-026 Result order SHALL equal acceptance order; no bundle dropped or duplicated.
REQ-027 txn_count SHALL increment by 1 on each output transfer and wrap from 16'hFFFF to 0.
REQ-028 Full throughput SHALL be one bundle per cycle when out_ready is held 1.

Reset
REQ-029 On rst_n low, asynchronously: all stage valids 0, out_valid 0, y 0, txn_count 0, all stage data 0.
REQ-030 Bundles in flight at reset assertion SHALL be discarded; first acceptance possible on first rising edge after rst_n deasserts.

Structure
REQ-031 A shared package SHALL hold the op enumeration (3-bit) and a result-width constant/function (2*W).
REQ-032 One sub-module expr_lane SHALL implement a single combinational lane (W, SIGNED params), instantiated LANES times via generate.

Verification
REQ-033 Signed lane 5, op 0, a=6'b111101 (-3), b=5 -> lane 5 y = 12'd2 after 2 cycles.
REQ-034 Unsigned lane 0, op 0, a=63, b=63 -> lane 0 y = 12'd126; op 6 -> 12'd3969.
REQ-035 Signed lane 3, op 5, a=-8, b=2 -> 12'hFFE (-2); unsigned lane 2, a=6'b111000, b=2 -> 12'd14.
REQ-036 out_ready=0, three bundles presented back-to-back -> in_ready drops once 2 held, out_valid stays, then out_ready=1 yields all three in order, txn_count=3.
REQ-037 rst_n pulsed low while out_valid=1 and txn_count=5 -> out_valid=0, y=0, txn_count=0 immediately, no stale result after release.
REQ-038 txn_count preloaded to 16'hFFFF by 65535 transfers, one more transfer -> 16'h0000.
